// File: rtl/bw_io_impctl_codestep.sv
// Impedance-calibration code stepper: runs averaging windows, steps the code by the
// averaging-counter sign, and locks once the direction dithers (two reversals in a row).
module bw_io_impctl_codestep #(
    parameter int                CODE_W     = 8,
    parameter logic [CODE_W-1:0] CODE_INIT  = 'h80,
    parameter int                WINDOW     = 16,
    parameter int                SAMPLE_DIV = 4,
    parameter int                RST_CYC    = 2,
    parameter int                SETTLE     = 8
) (
    input  logic              l2clk,
    input  logic              global_reset,
    input  logic              cal_en,
    input  logic              adv_sgn,
    output logic              sclk,
    output logic              avgcntr_rst,
    output logic [CODE_W-1:0] code,
    output logic              code_vld,
    output logic              locked,
    output logic              at_limit
);

    localparam int TMAX = (RST_CYC > SETTLE) ? RST_CYC : SETTLE;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int DW   = $clog2(SAMPLE_DIV + 1);
    localparam int SW   = $clog2(WINDOW + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CLEAR, ST_ACCUM, ST_DECIDE, ST_SETTLE, ST_LOCKED
    } state_t;

    state_t            r_state,  w_state_nxt;
    logic [TW-1:0]     r_tmr,    w_tmr_nxt;
    logic [DW-1:0]     r_div,    w_div_nxt;
    logic [SW-1:0]     r_scnt,   w_scnt_nxt;
    logic [CODE_W-1:0] r_code,   w_code_nxt;
    logic              r_vld,    w_vld_nxt;
    logic              r_locked, w_locked_nxt;
    logic              r_last_dir, w_last_dir_nxt;
    logic              r_dir_valid, w_dir_valid_nxt;
    logic [1:0]        r_rev,    w_rev_nxt;
    logic              w_strobe;

    // Strobe is gated by cal_en so an aborting cycle never emits a sample.
    assign w_strobe = (r_state == ST_ACCUM) && cal_en && (r_div == DW'(SAMPLE_DIV - 1));

    always_comb begin
        w_state_nxt     = r_state;
        w_tmr_nxt       = r_tmr;
        w_div_nxt       = r_div;
        w_scnt_nxt      = r_scnt;
        w_code_nxt      = r_code;
        w_vld_nxt       = 1'b0;
        w_locked_nxt    = r_locked;
        w_last_dir_nxt  = r_last_dir;
        w_dir_valid_nxt = r_dir_valid;
        w_rev_nxt       = r_rev;
        if (r_state != ST_IDLE && !cal_en) begin
            w_state_nxt     = ST_IDLE;
            w_tmr_nxt       = '0;
            w_div_nxt       = '0;
            w_scnt_nxt      = '0;
            w_locked_nxt    = 1'b0;
            w_dir_valid_nxt = 1'b0;
            w_rev_nxt       = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cal_en) begin
                        w_state_nxt = ST_CLEAR;
                        w_tmr_nxt   = '0;
                    end
                end
                ST_CLEAR: begin
                    if (r_tmr == TW'(RST_CYC - 1)) begin
                        w_state_nxt = ST_ACCUM;
                        w_tmr_nxt   = '0;
                        w_div_nxt   = '0;
                        w_scnt_nxt  = '0;
                    end else begin
                        w_tmr_nxt = r_tmr + TW'(1);
                    end
                end
                ST_ACCUM: begin
                    if (w_strobe) begin
                        w_div_nxt = '0;
                        if (r_scnt == SW'(WINDOW - 1)) begin
                            w_state_nxt = ST_DECIDE;
                            w_scnt_nxt  = '0;
                        end else begin
                            w_scnt_nxt = r_scnt + SW'(1);
                        end
                    end else begin
                        w_div_nxt = r_div + DW'(1);
                    end
                end
                ST_DECIDE: begin
                    w_vld_nxt       = 1'b1;
                    w_last_dir_nxt  = adv_sgn;
                    w_dir_valid_nxt = 1'b1;
                    if (adv_sgn && r_code != '1)
                        w_code_nxt = r_code + CODE_W'(1);
                    else if (!adv_sgn && r_code != '0)
                        w_code_nxt = r_code - CODE_W'(1);
                    // A repeat (or the first decision) zeroes the reversal run.
                    if (r_dir_valid && adv_sgn != r_last_dir)
                        w_rev_nxt = r_rev + 2'd1;
                    else
                        w_rev_nxt = '0;
                    if (w_rev_nxt == 2'd2) begin
                        w_locked_nxt = 1'b1;
                        w_state_nxt  = ST_LOCKED;
                    end else begin
                        w_state_nxt = ST_SETTLE;
                        w_tmr_nxt   = '0;
                    end
                end
                ST_SETTLE: begin
                    if (r_tmr == TW'(SETTLE - 1)) begin
                        w_state_nxt = ST_CLEAR;
                        w_tmr_nxt   = '0;
                    end else begin
                        w_tmr_nxt = r_tmr + TW'(1);
                    end
                end
                ST_LOCKED: begin
                    w_state_nxt = ST_LOCKED;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge l2clk) begin
        if (global_reset) begin
            r_state     <= ST_IDLE;
            r_tmr       <= '0;
            r_div       <= '0;
            r_scnt      <= '0;
            r_code      <= CODE_INIT;
            r_vld       <= 1'b0;
            r_locked    <= 1'b0;
            r_last_dir  <= 1'b0;
            r_dir_valid <= 1'b0;
            r_rev       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_tmr       <= w_tmr_nxt;
            r_div       <= w_div_nxt;
            r_scnt      <= w_scnt_nxt;
            r_code      <= w_code_nxt;
            r_vld       <= w_vld_nxt;
            r_locked    <= w_locked_nxt;
            r_last_dir  <= w_last_dir_nxt;
            r_dir_valid <= w_dir_valid_nxt;
            r_rev       <= w_rev_nxt;
        end
    end

    assign sclk        = w_strobe;
    assign avgcntr_rst = (r_state != ST_ACCUM);
    assign code        = r_code;
    assign code_vld    = r_vld;
    assign locked      = r_locked;
    assign at_limit    = (r_code == '0) || (r_code == '1);

endmodule

// File: tb/tb_bw_io_impctl_codestep.sv
// Bench for bw_io_impctl_codestep: directed scenarios plus random traffic, every cycle
// compared against a window-position model of the calibration schedule.
module tb_bw_io_impctl_codestep;

    localparam int RSTC = 2;
    localparam int ACC  = 16 * 4;
    localparam int DPOS = RSTC + ACC;        // window position of the decision cycle
    localparam int LEN  = DPOS + 1 + 8;      // positions per step, CLEAR through SETTLE

    logic       l2clk;
    logic       global_reset, cal_en, adv_sgn;
    logic       sclk, avgcntr_rst, code_vld, locked, at_limit;
    logic [7:0] code;

    bw_io_impctl_codestep dut (
        .l2clk(l2clk), .global_reset(global_reset), .cal_en(cal_en), .adv_sgn(adv_sgn),
        .sclk(sclk), .avgcntr_rst(avgcntr_rst), .code(code), .code_vld(code_vld),
        .locked(locked), .at_limit(at_limit)
    );

    initial l2clk = 1'b0;
    always #5 l2clk = ~l2clk;

    int n_chk = 0, n_fail = 0;
    int n_sclk, n_low, nc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 running at window position m_pos, 2 locked.
    int         m_mode = 0, m_pos = 0;
    logic [7:0] m_code = 8'h80;
    logic       m_vld = 1'b0, m_known = 1'b0;
    bit         hist[$];

    always @(posedge l2clk) begin
        if (global_reset) begin
            m_known = 1'b1; m_mode = 0; m_pos = 0; m_code = 8'h80; m_vld = 1'b0;
            hist.delete();
        end else if (m_known) begin
            m_vld = 1'b0;
            if (m_mode == 0) begin
                if (cal_en) begin m_mode = 1; m_pos = 0; end
            end else if (!cal_en) begin
                m_mode = 0; hist.delete();
            end else if (m_mode == 1) begin
                if (m_pos == DPOS) begin
                    if (adv_sgn && m_code != 8'hff) m_code = m_code + 8'd1;
                    else if (!adv_sgn && m_code != 8'h00) m_code = m_code - 8'd1;
                    m_vld = 1'b1;
                    hist.push_back(adv_sgn);
                    if (hist.size() >= 3 && hist[$] != hist[$-1] && hist[$-1] != hist[$-2])
                        m_mode = 2;
                    else
                        m_pos = m_pos + 1;
                end else begin
                    m_pos = (m_pos + 1) % LEN;
                end
            end
        end
    end

    task automatic tick(input logic r, input logic e, input logic a);
        logic in_acc;
        @(negedge l2clk);
        global_reset = r; cal_en = e; adv_sgn = a;
        #1;
        if (m_known) begin
            in_acc = (m_mode == 1) && (m_pos >= RSTC) && (m_pos < DPOS);
            chk("code", code, m_code);
            chk("code_vld", code_vld, m_vld);
            chk("locked", locked, m_mode == 2);
            chk("at_limit", at_limit, (m_code == 8'h00) || (m_code == 8'hff));
            chk("avgcntr_rst", avgcntr_rst, !in_acc);
            chk("sclk", sclk, in_acc && e && (((m_pos - RSTC) % 4) == 3));
        end
        if (sclk) n_sclk++;
        if (!avgcntr_rst) n_low++;
    endtask

    // Run enabled with a fixed sign until code_vld shows, counting cycles taken.
    task automatic step_win(input logic a, input int maxc, output int cyc);
        n_sclk = 0; n_low = 0; cyc = 0;
        do begin
            tick(1'b0, 1'b1, a);
            cyc++;
        end while (!code_vld && cyc < maxc);
        if (!code_vld) chk("vld_timeout", code_vld, 1'b1);
    endtask

    initial begin
        logic en;
        global_reset = 1'b1; cal_en = 1'b0; adv_sgn = 1'b0;
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("rst_code", code, 8'h80);
        chk("rst_avgrst", avgcntr_rst, 1'b1);
        chk("rst_locked", locked, 1'b0);

        // First window, then the step-to-step period
        step_win(1'b1, 200, nc);
        chk("first_cyc", nc, 69);
        chk("first_sclk", n_sclk, 16);
        chk("first_low", n_low, 64);
        chk("first_code", code, 8'h81);
        tick(1'b0, 1'b1, 1'b1);
        chk("vld_one_cycle", code_vld, 1'b0);
        step_win(1'b1, 200, nc);
        chk("period", nc, 74);
        chk("second_code", code, 8'h82);

        // Walk down to the lower limit
        tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 300 && code != 8'h01; i++) step_win(1'b0, 200, nc);
        chk("reach_01", code, 8'h01);
        chk("limit_off", at_limit, 1'b0);
        step_win(1'b0, 200, nc);
        chk("reach_00", code, 8'h00);
        chk("limit_on", at_limit, 1'b1);
        step_win(1'b0, 200, nc);
        chk("sat_code", code, 8'h00);
        chk("sat_vld", code_vld, 1'b1);

        // Dither 1,0,1 locks
        tick(1'b1, 1'b0, 1'b0);
        step_win(1'b1, 200, nc); chk("dith1", code, 8'h81); chk("dith1_lk", locked, 1'b0);
        step_win(1'b0, 200, nc); chk("dith2", code, 8'h80); chk("dith2_lk", locked, 1'b0);
        step_win(1'b1, 200, nc); chk("dith3", code, 8'h81); chk("dith3_lk", locked, 1'b1);
        n_sclk = 0;
        repeat (200) tick(1'b0, 1'b1, 1'($urandom));
        chk("lock_nosclk", n_sclk, 0);
        chk("lock_hold", code, 8'h81);
        chk("lock_stay", locked, 1'b1);

        // Abort right after strobe 7, then a full fresh window
        tick(1'b0, 1'b0, 1'b0);
        n_sclk = 0;
        for (int i = 0; i < 100 && n_sclk < 7; i++) tick(1'b0, 1'b1, 1'b1);
        chk("seven", n_sclk, 7);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        chk("abort_avgrst", avgcntr_rst, 1'b1);
        chk("abort_code", code, 8'h81);
        chk("abort_vld", code_vld, 1'b0);
        step_win(1'b1, 200, nc);
        chk("restart_sclk", n_sclk, 16);
        chk("restart_code", code, 8'h82);

        // Reset landing on the decision cycle at code 0x90
        tick(1'b1, 1'b0, 1'b0);
        repeat (16) step_win(1'b1, 200, nc);
        chk("reach_90", code, 8'h90);
        n_sclk = 0;
        for (int i = 0; i < 100 && n_sclk < 16; i++) tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        chk("dec_rst_code", code, 8'h80);
        chk("dec_rst_vld", code_vld, 1'b0);
        chk("dec_rst_lk", locked, 1'b0);

        // 1,0,0,1: repeat breaks the reversal run
        tick(1'b1, 1'b0, 1'b0);
        step_win(1'b1, 200, nc); chk("seq1", code, 8'h81);
        step_win(1'b0, 200, nc); chk("seq2", code, 8'h80);
        step_win(1'b0, 200, nc); chk("seq3", code, 8'h7f);
        step_win(1'b1, 200, nc); chk("seq4", code, 8'h80);
        chk("seq_nolock", locked, 1'b0);

        // Random traffic
        en = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if (en) en = ($urandom_range(0, 499) != 0);
            else    en = ($urandom_range(0, 4) == 0);
            tick(($urandom_range(0, 1999) == 0), en, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
